counter_game_driver: RTL and testbench
======================================

# counter_game_driver

Command-driven controller for the far end of the `multi_mode_counter` interface. It accepts queued play commands over a valid/ready handshake and drives `mode_control`, `load_value` and `init` into the counter. It consumes `GAMEOVER`/`WHO` to keep a per-side game tally and declares a match result after `MATCH_GAMES` wins. It sits between a host or sequencer and one `multi_mode_counter` instance.

## Interface
- `HOLD_W`, 8: width of `cmd_hold`.
- `MATCH_GAMES`, 3: wins needed to end a match; legal range 1..15.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_mode` in 2: mode to apply (00 +1, 01 +2, 10 -1, 11 -2).
- `cmd_init` in 1: pulse `init` with `cmd_load` before running.
- `cmd_load` in 4: load value used when `cmd_init`=1.
- `cmd_hold` in HOLD_W: command runs for `cmd_hold`+1 cycles.
- `match_clr` in 1: synchronous clear of tallies and match state.
- `mode_control` out 2: to counter.
- `load_value` out 4: to counter.
- `init` out 1: to counter; one-cycle pulse.
- `GAMEOVER` in 1: from counter.
- `WHO` in 2: from counter; 10 = winner side, 01 = loser side.
- `busy` out 1: high in any state except IDLE.
- `game_done` out 1: one-cycle pulse per game end.
- `winner_games` out 4: winner-side tally.
- `loser_games` out 4: loser-side tally.
- `match_over` out 1: sticky, set when a tally reaches `MATCH_GAMES`.
- `match_who` out 2: `WHO` code of the match winner; 00 until `match_over`.
- `proto_err` out 1: sticky; set on a `GAMEOVER` rising edge with `WHO` of 00 or 11.
- `cmds_accepted` out 16: statistics output (see Configuration).
- `cmds_aborted` out 8: statistics output (see Configuration).

## Operation
- States: IDLE, LOAD, RUN, FLUSH, MATCH.
- `cmd_ready` = (state==IDLE) && !`GAMEOVER` && !`match_over` (combinational).
- IDLE, on accept:
  - `cmd_init`=1: go to LOAD.
  - Otherwise: go to RUN.
  - In both cases latch mode, load value and hold.
- LOAD:
  - Lasts exactly one cycle.
  - `init`=1, `load_value`=latched load, `mode_control`=latched mode.
  - Then go to RUN.
- RUN:
  - `mode_control`=latched mode; hold counter decrements each cycle.
  - When the counter is 0, return to IDLE.
  - `mode_control` and `load_value` keep their last values in IDLE.
- `GAMEOVER` rising edge (registered previous value), in any state except MATCH:
  - Sample `WHO`.
  - 10: increment `winner_games`. 01: increment `loser_games`. Other codes: set `proto_err`, no tally change.
  - Pulse `game_done`.
  - An active LOAD/RUN command is aborted.
  - Go to FLUSH.
- FLUSH:
  - Hold outputs.
  - When `GAMEOVER` is low, go to MATCH if either tally equals `MATCH_GAMES`, else go to IDLE.
- MATCH:
  - `match_over`=1; `match_who`=10 or 01 per the side that reached `MATCH_GAMES`.
  - Further `GAMEOVER` edges are ignored; no commands accepted.
- Tallies saturate at 15.
- `match_clr`:
  - Highest priority after reset; takes effect in any state.
  - Zeroes tallies, `match_over`, `match_who` and `proto_err`; forces IDLE; drives `init`=0.
  - Discards a `GAMEOVER` edge in the same cycle.

## Timing
- All outputs are registered except `cmd_ready`.
- Reset values:
  - `mode_control`=00, `load_value`=0, `init`=0, `busy`=0, `game_done`=0.
  - Tallies 0, `match_over`=0, `match_who`=00, `proto_err`=0, stats 0.
  - State IDLE.
- Accept in cycle N:
  - With init: `init`=1 in cycle N+1; RUN covers N+2..N+2+hold.
  - Without init: RUN covers N+1..N+1+hold.
  - `cmd_ready` returns high the cycle after the last RUN cycle.
- `game_done` and tally update occur the cycle after `GAMEOVER` is first sampled high. `busy` is high from that same cycle.
- `GAMEOVER` held high over multiple cycles counts as one game.

## Configuration
- `GAME_DRV_STATS_EN` defined:
  - `cmds_accepted` counts handshakes, saturating at 0xFFFF.
  - `cmds_aborted` counts commands cut short by `GAMEOVER`, saturating at 0xFF.
  - Both are cleared by reset only.
- Undefined: both outputs are tied to 0 and no counter logic is synthesized.

## Test plan
- Reset release, `cmd_valid`=1, mode=01, init=0, hold=3 -> `mode_control`=01 for 4 cycles from the cycle after accept; `cmd_ready` low for 4 cycles, then high.
- Command init=1, load=14, mode=11, hold=0 -> `init`=1 for one cycle with `load_value`=14; one RUN cycle follows; back in IDLE 2 cycles after the init pulse.
- `GAMEOVER` high for 3 cycles with `WHO`=10 mid-RUN (hold=20) -> one `game_done` pulse; `winner_games`=1; command aborted (`cmds_aborted`=1 with macro); IDLE after `GAMEOVER` falls.
- Three `GAMEOVER`/`WHO`=01 events -> `loser_games`=3, `match_over`=1, `match_who`=01; `cmd_ready` stays 0 with `cmd_valid` high; a fourth event leaves the tally unchanged.
- `GAMEOVER` with `WHO`=11 -> `proto_err`=1, tallies unchanged; then `match_clr` -> all tallies, `proto_err` and `match_over` are 0 and `cmd_ready`=1 next cycle.
- `rst_n` low during LOAD -> `init` drops to 0 immediately (asynchronous); all outputs at reset values.

Source files
------------

// File: rtl/counter_game_driver.sv
// Command-driven controller feeding a multi_mode_counter and tallying its games.
// Define GAME_DRV_STATS_EN to build the accepted/aborted command counters.
module counter_game_driver #(
    parameter int HOLD_W      = 8,
    parameter int MATCH_GAMES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic              cmd_init,
    input  logic [3:0]        cmd_load,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              match_clr,
    output logic [1:0]        mode_control,
    output logic [3:0]        load_value,
    output logic              init,
    input  logic              GAMEOVER,
    input  logic [1:0]        WHO,
    output logic              busy,
    output logic              game_done,
    output logic [3:0]        winner_games,
    output logic [3:0]        loser_games,
    output logic              match_over,
    output logic [1:0]        match_who,
    output logic              proto_err,
    output logic [15:0]       cmds_accepted,
    output logic [7:0]        cmds_aborted
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FLUSH,
        MATCH
    } state_t;

    localparam logic [3:0] MG = 4'(MATCH_GAMES);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              gameover_q;
    logic              go_rise;
    logic              accept;

    assign go_rise   = GAMEOVER && !gameover_q && (state != MATCH);
    assign cmd_ready = (state == IDLE) && !GAMEOVER && !match_over;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            gameover_q   <= 1'b0;
            mode_control <= 2'b00;
            load_value   <= 4'd0;
            init         <= 1'b0;
            busy         <= 1'b0;
            game_done    <= 1'b0;
            winner_games <= 4'd0;
            loser_games  <= 4'd0;
            match_over   <= 1'b0;
            match_who    <= 2'b00;
            proto_err    <= 1'b0;
        end else begin
            gameover_q <= GAMEOVER;
            game_done  <= 1'b0;
            if (match_clr) begin
                state        <= IDLE;
                init         <= 1'b0;
                busy         <= 1'b0;
                winner_games <= 4'd0;
                loser_games  <= 4'd0;
                match_over   <= 1'b0;
                match_who    <= 2'b00;
                proto_err    <= 1'b0;
            end else if (go_rise) begin
                // a game end preempts whatever command is running
                game_done <= 1'b1;
                state     <= FLUSH;
                busy      <= 1'b1;
                init      <= 1'b0;
                unique case (1'b1)
                    (WHO == 2'b10): begin
                        if (winner_games != 4'd15)
                            winner_games <= winner_games + 4'd1;
                    end
                    (WHO == 2'b01): begin
                        if (loser_games != 4'd15)
                            loser_games <= loser_games + 4'd1;
                    end
                    default: proto_err <= 1'b1;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            mode_control <= cmd_mode;
                            hold_cnt     <= cmd_hold;
                            busy         <= 1'b1;
                            if (cmd_init) begin
                                load_value <= cmd_load;
                                init       <= 1'b1;
                                state      <= LOAD;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                    LOAD: begin
                        init  <= 1'b0;
                        state <= RUN;
                    end
                    RUN: begin
                        if (hold_cnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                    FLUSH: begin
                        if (!GAMEOVER) begin
                            if (winner_games == MG) begin
                                state      <= MATCH;
                                match_over <= 1'b1;
                                match_who  <= 2'b10;
                            end else if (loser_games == MG) begin
                                state      <= MATCH;
                                match_over <= 1'b1;
                                match_who  <= 2'b01;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    MATCH: ;
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef GAME_DRV_STATS_EN
    logic abort;

    assign abort = go_rise && !match_clr &&
                   ((state == LOAD) || (state == RUN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmds_accepted <= 16'd0;
            cmds_aborted  <= 8'd0;
        end else begin
            if (accept && (cmds_accepted != 16'hFFFF))
                cmds_accepted <= cmds_accepted + 16'd1;
            if (abort && (cmds_aborted != 8'hFF))
                cmds_aborted <= cmds_aborted + 8'd1;
        end
    end
`else
    assign cmds_accepted = 16'd0;
    assign cmds_aborted  = 8'd0;
`endif

endmodule

// File: tb/tb_counter_game_driver.sv
// Directed bench for counter_game_driver with a cycle-level reference model.
module tb_counter_game_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_mode = 2'b00;
    logic        cmd_init = 1'b0;
    logic [3:0]  cmd_load = 4'd0;
    logic [7:0]  cmd_hold = 8'd0;
    logic        match_clr = 1'b0;
    logic [1:0]  mode_control;
    logic [3:0]  load_value;
    logic        init;
    logic        GAMEOVER = 1'b0;
    logic [1:0]  WHO = 2'b00;
    logic        busy;
    logic        game_done;
    logic [3:0]  winner_games;
    logic [3:0]  loser_games;
    logic        match_over;
    logic [1:0]  match_who;
    logic        proto_err;
    logic [15:0] cmds_accepted;
    logic [7:0]  cmds_aborted;

    int checks = 0;
    int errors = 0;
    int gd_cnt = 0;

    counter_game_driver #(.HOLD_W(8), .MATCH_GAMES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_init(cmd_init),
        .cmd_load(cmd_load), .cmd_hold(cmd_hold),
        .match_clr(match_clr),
        .mode_control(mode_control), .load_value(load_value),
        .init(init), .GAMEOVER(GAMEOVER), .WHO(WHO),
        .busy(busy), .game_done(game_done),
        .winner_games(winner_games), .loser_games(loser_games),
        .match_over(match_over), .match_who(match_who),
        .proto_err(proto_err),
        .cmds_accepted(cmds_accepted), .cmds_aborted(cmds_aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: remaining RUN cycles, a pending load cycle,
    // and flags for flushing a game end or sitting in a finished match.
    int         m_run = 0;
    int         m_hold = 0;
    bit         m_load = 0, m_flush = 0, m_match = 0;
    bit         m_go = 0, m_gd = 0, m_over = 0, m_perr = 0;
    logic [1:0] m_mode = 2'b00, m_who = 2'b00;
    logic [3:0] m_lv = 4'd0, m_w = 4'd0, m_l = 4'd0;
    int         m_acc = 0, m_ab = 0;

    function automatic bit m_idle();
        return !m_load && (m_run == 0) && !m_flush && !m_match;
    endfunction

    function automatic bit m_ready();
        return m_idle() && !GAMEOVER && !m_over;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_run = 0; m_hold = 0; m_load = 0; m_flush = 0; m_match = 0;
            m_go = 0; m_gd = 0; m_over = 0; m_perr = 0;
            m_mode = 0; m_who = 0; m_lv = 0; m_w = 0; m_l = 0;
            m_acc = 0; m_ab = 0;
        end else begin
            bit acc, rise;
            acc  = m_ready() && cmd_valid;
            rise = GAMEOVER && !m_go && !m_match;
            m_go = GAMEOVER;
            m_gd = 0;
            if (acc && m_acc < 65535) m_acc++;
            if (match_clr) begin
                m_w = 0; m_l = 0; m_over = 0; m_who = 0; m_perr = 0;
                m_load = 0; m_run = 0; m_flush = 0; m_match = 0;
            end else if (rise) begin
                if (WHO == 2'b10) m_w = (m_w == 15) ? m_w : m_w + 1;
                else if (WHO == 2'b01) m_l = (m_l == 15) ? m_l : m_l + 1;
                else m_perr = 1;
                m_gd = 1;
                if ((m_load || m_run > 0) && m_ab < 255) m_ab++;
                m_load = 0; m_run = 0; m_flush = 1;
            end else if (m_flush) begin
                if (!GAMEOVER) begin
                    m_flush = 0;
                    if (m_w == 3) begin
                        m_match = 1; m_over = 1; m_who = 2'b10;
                    end else if (m_l == 3) begin
                        m_match = 1; m_over = 1; m_who = 2'b01;
                    end
                end
            end else if (m_load) begin
                m_load = 0;
                m_run  = m_hold + 1;
            end else if (m_run > 0) begin
                m_run--;
            end else if (acc) begin
                m_mode = cmd_mode;
                if (cmd_init) begin
                    m_load = 1; m_lv = cmd_load; m_hold = int'(cmd_hold);
                end else begin
                    m_run = int'(cmd_hold) + 1;
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (game_done) gd_cnt++;
            chk("cmd_ready", 16'(cmd_ready), 16'(m_ready()));
            chk("mode_control", 16'(mode_control), 16'(m_mode));
            chk("load_value", 16'(load_value), 16'(m_lv));
            chk("init", 16'(init), 16'(m_load));
            chk("busy", 16'(busy), 16'(!m_idle()));
            chk("game_done", 16'(game_done), 16'(m_gd));
            chk("winner_games", 16'(winner_games), 16'(m_w));
            chk("loser_games", 16'(loser_games), 16'(m_l));
            chk("match_over", 16'(match_over), 16'(m_over));
            chk("match_who", 16'(match_who), 16'(m_who));
            chk("proto_err", 16'(proto_err), 16'(m_perr));
`ifdef GAME_DRV_STATS_EN
            chk("cmds_accepted", cmds_accepted, 16'(m_acc));
            chk("cmds_aborted", 16'(cmds_aborted), 16'(m_ab));
`else
            chk("cmds_accepted", cmds_accepted, 16'd0);
            chk("cmds_aborted", 16'(cmds_aborted), 16'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic game(logic [1:0] who, int hi);
        GAMEOVER = 1'b1;
        WHO = who;
        repeat (hi) tick();
        GAMEOVER = 1'b0;
        WHO = 2'b00;
        repeat (3) tick();
    endtask

    task automatic issue(logic [1:0] md, logic in, logic [3:0] ld, logic [7:0] hd);
        cmd_valid = 1'b1;
        cmd_mode = md;
        cmd_init = in;
        cmd_load = ld;
        cmd_hold = hd;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int gd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_ready", 16'(cmd_ready), 16'd1);
        chk("rst_mode", 16'(mode_control), 16'd0);

        // mode 01, no init, hold 3
        tick();
        issue(2'b01, 1'b0, 4'd0, 8'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_ready_low", 16'(cmd_ready), 16'd0);
            chk("t1_mode", 16'(mode_control), 16'h1);
        end
        @(negedge clk);
        chk("t1_ready_back", 16'(cmd_ready), 16'd1);

        // init with load 14, mode 11, hold 0
        tick();
        issue(2'b11, 1'b1, 4'd14, 8'd0);
        @(negedge clk);
        chk("t2_init", 16'(init), 16'd1);
        chk("t2_load", 16'(load_value), 16'd14);
        @(negedge clk);
        chk("t2_run_init", 16'(init), 16'd0);
        chk("t2_run_busy", 16'(busy), 16'd1);
        @(negedge clk);
        chk("t2_idle", 16'(cmd_ready), 16'd1);

        // game end in the middle of a long command
        tick();
        issue(2'b00, 1'b0, 4'd0, 8'd20);
        repeat (5) tick();
        gd0 = gd_cnt;
        game(2'b10, 3);
        @(negedge clk);
        chk("t3_winner", 16'(winner_games), 16'd1);
        chk("t3_pulses", 16'(gd_cnt - gd0), 16'd1);
        chk("t3_ready", 16'(cmd_ready), 16'd1);
`ifdef GAME_DRV_STATS_EN
        chk("t3_aborted", 16'(cmds_aborted), 16'd1);
        chk("t3_accepted", cmds_accepted, 16'd3);
`endif

        // loser side takes the match
        tick();
        repeat (3) game(2'b01, 2);
        @(negedge clk);
        chk("t4_loser", 16'(loser_games), 16'd3);
        chk("t4_over", 16'(match_over), 16'd1);
        chk("t4_who", 16'(match_who), 16'h1);
        tick();
        cmd_valid = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("t4_ready_low", 16'(cmd_ready), 16'd0);
        tick();
        game(2'b01, 2);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("t4_loser_held", 16'(loser_games), 16'd3);

        // clear, then a bad WHO code
        tick();
        match_clr = 1'b1;
        tick();
        match_clr = 1'b0;
        @(negedge clk);
        chk("t5_clr_over", 16'(match_over), 16'd0);
        chk("t5_clr_ready", 16'(cmd_ready), 16'd1);
        tick();
        game(2'b10, 2);
        game(2'b11, 2);
        @(negedge clk);
        chk("t5_perr", 16'(proto_err), 16'd1);
        chk("t5_winner", 16'(winner_games), 16'd1);
        chk("t5_loser", 16'(loser_games), 16'd0);

        // clear coinciding with a game edge discards the edge
        tick();
        match_clr = 1'b1;
        GAMEOVER = 1'b1;
        WHO = 2'b10;
        tick();
        match_clr = 1'b0;
        repeat (2) tick();
        GAMEOVER = 1'b0;
        WHO = 2'b00;
        repeat (2) tick();
        @(negedge clk);
        chk("t5_disc_winner", 16'(winner_games), 16'd0);
        chk("t5_disc_perr", 16'(proto_err), 16'd0);
        chk("t5_disc_ready", 16'(cmd_ready), 16'd1);

        // asynchronous reset during LOAD
        tick();
        issue(2'b10, 1'b1, 4'd5, 8'd4);
        @(negedge clk);
        chk("t6_init", 16'(init), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_init", 16'(init), 16'd0);
        chk("t6_rst_busy", 16'(busy), 16'd0);
        chk("t6_rst_load", 16'(load_value), 16'd0);
        chk("t6_rst_mode", 16'(mode_control), 16'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
